// File: rtl/onchip_ram_2port_arb.sv
// Two-port Avalon-MM on-chip RAM: round-robin arbitration onto one single-port array.
// Optional per-lane even parity when ONCHIP_RAM_PARITY_EN is defined.
module onchip_ram_2port_arb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 5000,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_parity_err,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic                s2_waitrequest,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_parity_err,
    output logic [7:0]          parity_err_cnt
);

    localparam int              BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic                req1_s, req2_s, gnt1_s, gnt2_s;
    logic                ptr_q, ptr_d;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [BE_W-1:0]     acc_be_s;
    logic [DATA_W-1:0]   acc_wd_s;
    logic                acc_we_s, in_range_s;
    logic [1:0]          acc_rd_s;
    logic [DATA_W-1:0]   rd_data_s;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                vld_q [2][READ_LAT];
    logic                vld_d [2][READ_LAT];
    logic [DATA_W-1:0]   dat_q [2][READ_LAT];
    logic [DATA_W-1:0]   dat_d [2][READ_LAT];

    assign req1_s = s1_chipselect & (s1_read | s1_write);
    assign req2_s = s2_chipselect & (s2_read | s2_write);

    // Round-robin grant; ptr_q=0 favours s1 and only moves on a contested grant.
    always_comb begin
        gnt1_s = 1'b0;
        gnt2_s = 1'b0;
        ptr_d  = ptr_q;
        if (clken) begin
            if (req1_s && req2_s) begin
                if (ptr_q == 1'b0) begin
                    gnt1_s = 1'b1;
                    ptr_d  = 1'b1;
                end else begin
                    gnt2_s = 1'b1;
                    ptr_d  = 1'b0;
                end
            end else begin
                gnt1_s = req1_s;
                gnt2_s = req2_s;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    assign s1_waitrequest = (req1_s & ~gnt1_s) | ~clken;
    assign s2_waitrequest = (req2_s & ~gnt2_s) | ~clken;

    // Steer the granted port onto the shared array.
    always_comb begin
        acc_addr_s = s1_address;
        acc_be_s   = s1_byteenable;
        acc_wd_s   = s1_writedata;
        if (gnt2_s) begin
            acc_addr_s = s2_address;
            acc_be_s   = s2_byteenable;
            acc_wd_s   = s2_writedata;
        end else begin
            acc_addr_s = s1_address;
            acc_be_s   = s1_byteenable;
            acc_wd_s   = s1_writedata;
        end
    end

    assign acc_we_s    = (gnt1_s & s1_write) | (gnt2_s & s2_write);
    assign acc_rd_s[0] = gnt1_s & s1_read & ~s1_write;
    assign acc_rd_s[1] = gnt2_s & s2_read & ~s2_write;
    assign in_range_s  = ({1'b0, acc_addr_s} < DEPTH_C);
    assign rd_data_s   = in_range_s ? mem_q[acc_addr_s] : {DATA_W{1'b0}};

    // Byte-lane array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_we_s && in_range_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be_s[b]) begin
                    mem_q[acc_addr_s][b*8 +: 8] <= acc_wd_s[b*8 +: 8];
                end
            end
        end
    end

    // Per-port read pipelines; they advance only while clken is high.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clken) begin
            for (int p = 0; p < 2; p++) begin
                vld_d[p][0] = acc_rd_s[p];
                dat_d[p][0] = acc_rd_s[p] ? rd_data_s : dat_q[p][0];
                for (int i = 1; i < READ_LAT; i++) begin
                    vld_d[p][i] = vld_q[p][i-1];
                    dat_d[p][i] = dat_q[p][i-1];
                end
            end
        end else begin
            vld_d = vld_q;
            dat_d = dat_q;
        end
    end

    // Arbitration pointer and read pipeline state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < READ_LAT; i++) begin
                    vld_q[p][i] <= 1'b0;
                    dat_q[p][i] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    // A held result is shown only in an enabled cycle, so a freeze never duplicates it.
    assign s1_readdatavalid = vld_q[0][READ_LAT-1] & clken;
    assign s2_readdatavalid = vld_q[1][READ_LAT-1] & clken;
    assign s1_readdata      = dat_q[0][READ_LAT-1];
    assign s2_readdata      = dat_q[1][READ_LAT-1];

`ifdef ONCHIP_RAM_PARITY_EN
    logic [BE_W-1:0] par_q [DEPTH];
    logic            perr_in_s;
    logic            perr_q [2][READ_LAT];
    logic            perr_d [2][READ_LAT];
    logic [7:0]      cnt_q, cnt_d;
    logic [8:0]      cnt_sum_s;

    function automatic logic [BE_W-1:0] lane_parity(input logic [DATA_W-1:0] d);
        logic [BE_W-1:0] p;
        for (int b = 0; b < BE_W; b++) begin
            p[b] = ^d[b*8 +: 8];
        end
        return p;
    endfunction

    assign perr_in_s = in_range_s & (|(par_q[acc_addr_s] ^ lane_parity(mem_q[acc_addr_s])));

    // Parity bits are written lane by lane alongside the data.
    always_ff @(posedge clk) begin
        if (acc_we_s && in_range_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be_s[b]) begin
                    par_q[acc_addr_s][b] <= ^acc_wd_s[b*8 +: 8];
                end
            end
        end
    end

    // Error flags ride the read pipeline; the counter adds each flag as it is delivered.
    always_comb begin
        perr_d    = perr_q;
        cnt_d     = cnt_q;
        cnt_sum_s = {1'b0, cnt_q} + {8'h00, perr_q[0][READ_LAT-1]} + {8'h00, perr_q[1][READ_LAT-1]};
        if (clken) begin
            for (int p = 0; p < 2; p++) begin
                perr_d[p][0] = acc_rd_s[p] & perr_in_s;
                for (int i = 1; i < READ_LAT; i++) begin
                    perr_d[p][i] = perr_q[p][i-1];
                end
            end
            cnt_d = cnt_sum_s[8] ? 8'hFF : cnt_sum_s[7:0];
        end else begin
            perr_d = perr_q;
            cnt_d  = cnt_q;
        end
    end

    // Parity flag pipeline and saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'h00;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < READ_LAT; i++) begin
                    perr_q[p][i] <= 1'b0;
                end
            end
        end else begin
            cnt_q  <= cnt_d;
            perr_q <= perr_d;
        end
    end

    assign s1_parity_err  = perr_q[0][READ_LAT-1] & clken;
    assign s2_parity_err  = perr_q[1][READ_LAT-1] & clken;
    assign parity_err_cnt = cnt_q;
`else
    assign s1_parity_err  = 1'b0;
    assign s2_parity_err  = 1'b0;
    assign parity_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_onchip_ram_2port_arb.sv
// Randomized bench for onchip_ram_2port_arb against a transaction-level memory/arbiter model.
module tb_onchip_ram_2port_arb;
    localparam int DATA_W = 32, ADDR_W = 13, DEPTH = 5000, READ_LAT = 1;

    logic clk = 1'b0;
    logic reset_n, clken;
    logic [12:0] s1_address, s2_address;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic s1_waitrequest, s1_readdatavalid, s1_parity_err;
    logic s2_waitrequest, s2_readdatavalid, s2_parity_err;
    logic [7:0] parity_err_cnt;

    onchip_ram_2port_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid), .s1_parity_err(s1_parity_err),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata),
        .s2_readdatavalid(s2_readdatavalid), .s2_parity_err(s2_parity_err),
        .parity_err_cnt(parity_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] d; logic pe; logic port; logic [7:0] age; } ent_t;
    ent_t        pend[$];
    logic [31:0] mem_m [DEPTH];
    bit          flip_m [DEPTH];
    bit          m_cs[2], m_rd[2], m_wr[2];
    logic [12:0] m_addr[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_wd[2];
    bit          clken_m = 1'b1;
    int          last_cont = 2;
    int          cnt_m = 0;
    int          checks = 0, errors = 0, cyc = 0;
    bit          g[2];
    logic [31:0] last_rd[2];
    int          rdv_seen[2], perr_seen[2], acc_cyc[2], rdv_cyc[2];
    int          grant_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive_pins();
        s1_chipselect = m_cs[0]; s1_read = m_rd[0]; s1_write = m_wr[0];
        s1_address = m_addr[0]; s1_byteenable = m_be[0]; s1_writedata = m_wd[0];
        s2_chipselect = m_cs[1]; s2_read = m_rd[1]; s2_write = m_wr[1];
        s2_address = m_addr[1]; s2_byteenable = m_be[1]; s2_writedata = m_wd[1];
        clken = clken_m;
    endtask

    function automatic int find_vis(input int p);
        foreach (pend[i]) if (pend[i].port == p[0] && pend[i].age == 8'(READ_LAT)) return i;
        return -1;
    endfunction

    // One clock: drive, compare against the model, then advance the model at the edge.
    task automatic cycle();
        bit r[2], vis[2];
        int vi[2];
        logic wq[2], rv[2], pe[2];
        logic [31:0] rdata[2];
        ent_t e;
        ent_t keep[$];
        @(negedge clk);
        drive_pins();
        #2;
        for (int p = 0; p < 2; p++) begin
            r[p] = m_cs[p] & (m_rd[p] | m_wr[p]);
            g[p] = 1'b0;
        end
        if (clken_m) begin
            if (r[0] && r[1]) begin
                if (last_cont == 1) g[1] = 1'b1; else g[0] = 1'b1;
            end else begin
                g[0] = r[0]; g[1] = r[1];
            end
        end
        wq[0] = s1_waitrequest; rv[0] = s1_readdatavalid; rdata[0] = s1_readdata; pe[0] = s1_parity_err;
        wq[1] = s2_waitrequest; rv[1] = s2_readdatavalid; rdata[1] = s2_readdata; pe[1] = s2_parity_err;
        for (int p = 0; p < 2; p++) begin
            vi[p]  = find_vis(p);
            vis[p] = clken_m && (vi[p] >= 0);
            chk($sformatf("s%0d_waitrequest", p + 1), wq[p], (r[p] && !g[p]) || !clken_m);
            chk($sformatf("s%0d_readdatavalid", p + 1), rv[p], vis[p]);
            chk($sformatf("s%0d_parity_err", p + 1), pe[p], vis[p] ? pend[vi[p]].pe : 1'b0);
            if (vis[p]) begin
                chk($sformatf("s%0d_readdata", p + 1), rdata[p], pend[vi[p]].d);
                last_rd[p] = rdata[p];
                rdv_seen[p]++;
                rdv_cyc[p] = cyc;
                if (pe[p]) perr_seen[p]++;
            end
        end
        chk("parity_err_cnt", parity_err_cnt, cnt_m);
        @(posedge clk);
        if (clken_m) begin
            for (int p = 0; p < 2; p++) begin
                if (vis[p] && pend[vi[p]].pe && cnt_m < 255) cnt_m++;
            end
            foreach (pend[i]) begin
                e = pend[i];
                e.age = e.age + 8'd1;
                if (e.age <= 8'(READ_LAT)) keep.push_back(e);
            end
            pend = keep;
            for (int p = 0; p < 2; p++) begin
                if (g[p]) begin
                    if (m_wr[p]) begin
                        if (m_addr[p] < 13'(DEPTH)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (m_be[p][b]) mem_m[m_addr[p]][b*8 +: 8] = m_wd[p][b*8 +: 8];
                            end
                            if (m_be[p] == 4'hF) flip_m[m_addr[p]] = 1'b0;
                        end
                    end else begin
                        e.d    = (m_addr[p] < 13'(DEPTH)) ? mem_m[m_addr[p]] : 32'h0000_0000;
                        e.pe   = (m_addr[p] < 13'(DEPTH)) ? flip_m[m_addr[p]] : 1'b0;
                        e.port = p[0];
                        e.age  = 8'd1;
                        pend.push_back(e);
                    end
                    acc_cyc[p] = cyc;
                    grant_log.push_back(p);
                    m_cs[p] = 1'b0;
                end
            end
            if (r[0] && r[1]) last_cont = g[0] ? 1 : 2;
        end
        cyc++;
    endtask

    task automatic xfer(input int p, input bit rd, input bit wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        int k;
        m_rd[p] = rd; m_wr[p] = wr; m_addr[p] = a; m_be[p] = be; m_wd[p] = wd; m_cs[p] = 1'b1;
        k = 0;
        while (m_cs[p] && k < 50) begin
            cycle();
            k++;
        end
        chk("xfer_grant_timeout", m_cs[p], 1'b0);
        m_cs[p] = 1'b0;
    endtask

    task automatic wait_rdv(input int p, input int n0);
        int k;
        k = 0;
        while (rdv_seen[p] == n0 && k < 20) begin
            cycle();
            k++;
        end
        chk("read_return_timeout", rdv_seen[p] > n0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        m_cs[0] = 1'b0; m_cs[1] = 1'b0;
        s1_chipselect = 1'b0; s2_chipselect = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("reset_s1_readdatavalid", s1_readdatavalid, 1'b0);
        chk("reset_s2_readdatavalid", s2_readdatavalid, 1'b0);
        chk("reset_parity_err_cnt", parity_err_cnt, 8'h00);
        pend.delete();
        last_cont = 2;
        cnt_m = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic logic [12:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 13'($urandom_range(0, 47));
        else if (r < 8) return 13'($urandom_range(4990, 4999));
        else return 13'($urandom_range(5000, 8191));
    endfunction

    initial begin
        int n0, kind;
        for (int p = 0; p < 2; p++) begin
            m_cs[p] = 1'b0; m_rd[p] = 1'b0; m_wr[p] = 1'b0; m_addr[p] = 13'h0;
            m_be[p] = 4'h0; m_wd[p] = 32'h0; rdv_seen[p] = 0; perr_seen[p] = 0;
        end
        reset_n = 1'b0;
        drive_pins();
        #3;
        chk("rst_s1_waitrequest", s1_waitrequest, 1'b0);
        chk("rst_s2_waitrequest", s2_waitrequest, 1'b0);
        chk("rst_s1_readdatavalid", s1_readdatavalid, 1'b0);
        chk("rst_s2_readdatavalid", s2_readdatavalid, 1'b0);
        chk("rst_s1_readdata", s1_readdata, 32'h0);
        chk("rst_s2_readdata", s2_readdata, 32'h0);
        chk("rst_s1_parity_err", s1_parity_err, 1'b0);
        chk("rst_s2_parity_err", s2_parity_err, 1'b0);
        chk("rst_parity_err_cnt", parity_err_cnt, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int a = 0; a < 48; a++) xfer(0, 1'b0, 1'b1, 13'(a), 4'hF, $urandom);
        for (int a = 4990; a < 5000; a++) xfer(0, 1'b0, 1'b1, 13'(a), 4'hF, $urandom);

        // Full-word write then read back with the configured latency.
        xfer(0, 1'b0, 1'b1, 13'h010, 4'hF, 32'hDEADBEEF);
        n0 = rdv_seen[0];
        xfer(0, 1'b1, 1'b0, 13'h010, 4'h0, 32'h0);
        wait_rdv(0, n0);
        chk("deadbeef_data", last_rd[0], 32'hDEADBEEF);
        chk("deadbeef_latency", rdv_cyc[0] - acc_cyc[0], READ_LAT);

        // Partial byte-lane write seen from the other port.
        xfer(0, 1'b0, 1'b1, 13'h020, 4'hF, 32'hAAAAAAAA);
        xfer(0, 1'b0, 1'b1, 13'h020, 4'b0101, 32'h11223344);
        n0 = rdv_seen[1];
        xfer(1, 1'b1, 1'b0, 13'h020, 4'h0, 32'h0);
        wait_rdv(1, n0);
        chk("byteenable_merge", last_rd[1], 32'hAA22AA44);

        // Read+write together acts as a write with no return.
        n0 = rdv_seen[1];
        xfer(1, 1'b1, 1'b1, 13'h021, 4'hF, 32'h5A5A0001);
        repeat (4) cycle();
        chk("rw_no_readdatavalid", rdv_seen[1] - n0, 0);

        // Contested arbitration alternates, s1 first after reset.
        do_reset();
        grant_log.delete();
        for (int p = 0; p < 2; p++) begin
            m_rd[p] = 1'b1; m_wr[p] = 1'b0; m_addr[p] = 13'h010; m_cs[p] = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            for (int p = 0; p < 2; p++) m_cs[p] = 1'b1;
        end
        m_cs[0] = 1'b0; m_cs[1] = 1'b0;
        chk("contest_grant_count", grant_log.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("contest_grant_%0d", k), grant_log[k], k % 2);
        repeat (3) cycle();

        // Out-of-range accesses.
        xfer(0, 1'b0, 1'b1, 13'h000, 4'hF, 32'hCAFE0000);
        n0 = rdv_seen[1];
        xfer(1, 1'b1, 1'b0, 13'd5000, 4'h0, 32'h0);
        wait_rdv(1, n0);
        chk("oor_read_zero", last_rd[1], 32'h0);
        xfer(1, 1'b0, 1'b1, 13'd5000, 4'hF, 32'h12345678);
        n0 = rdv_seen[1];
        xfer(1, 1'b1, 1'b0, 13'h000, 4'h0, 32'h0);
        wait_rdv(1, n0);
        chk("oor_write_dropped", last_rd[1], 32'hCAFE0000);

        // Clock-enable freeze with a read in flight and a request waiting.
        n0 = rdv_seen[0];
        xfer(0, 1'b1, 1'b0, 13'h010, 4'h0, 32'h0);
        clken_m = 1'b0;
        m_rd[1] = 1'b1; m_wr[1] = 1'b0; m_addr[1] = 13'h020; m_cs[1] = 1'b1;
        repeat (3) cycle();
        chk("freeze_no_early_rdv", rdv_seen[0] - n0, 0);
        clken_m = 1'b1;
        repeat (4) cycle();
        chk("freeze_single_rdv", rdv_seen[0] - n0, 1);
        chk("freeze_data", last_rd[0], 32'hDEADBEEF);

        // Reset with a read in flight.
        xfer(0, 1'b1, 1'b0, 13'h010, 4'h0, 32'h0);
        do_reset();
        repeat (3) cycle();

`ifdef ONCHIP_RAM_PARITY_EN
        xfer(0, 1'b0, 1'b1, 13'h030, 4'hF, 32'h0F0F0F0F);
        repeat (2) cycle();
        dut.mem_q[48] = dut.mem_q[48] ^ 32'h0000_0001;
        mem_m[48] = mem_m[48] ^ 32'h0000_0001;
        flip_m[48] = 1'b1;
        chk("parity_cnt_before", parity_err_cnt, 8'h00);
        n0 = rdv_seen[0];
        xfer(0, 1'b1, 1'b0, 13'h030, 4'h0, 32'h0);
        wait_rdv(0, n0);
        chk("parity_err_seen", perr_seen[0], 1);
        #1;
        chk("parity_cnt_after", parity_err_cnt, 8'h01);
        do_reset();
`endif

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            clken_m = ($urandom_range(0, 5) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!m_cs[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        kind = $urandom_range(0, 3);
                        m_rd[p] = (kind != 2);
                        m_wr[p] = (kind >= 2);
                        m_addr[p] = pick_addr();
                        m_be[p] = 4'($urandom);
                        m_wd[p] = $urandom;
                        m_cs[p] = 1'b1;
                    end else begin
                        m_rd[p] = 1'($urandom);
                        m_wr[p] = 1'($urandom);
                    end
                end
            end
            cycle();
        end
        clken_m = 1'b1;
        m_cs[0] = 1'b0; m_cs[1] = 1'b0;
        repeat (6) cycle();
        chk("pending_drained", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
